cpu_clock_ctrl: RTL and testbench
=================================

Name: cpu_clock_ctrl

Overview:
Run/pause/single-step controller for the CPU clock domain. It replaces the free-running divided clock with a one-cycle clock-enable pulse, `tick`, on the system clock. The CPU datapath advances only on cycles where `tick` is high. It debounces the board's go and step buttons, provides eight selectable run rates, honours a halt request from the CPU and counts the ticks it has issued.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz; must be at least 4096.
DEB_CYCLES, 1_000_000, number of consecutive stable cycles a button must hold before a press is accepted.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  synchronous, active-high reset.
go_btn  input  1  raw asynchronous button; each accepted press toggles run/pause.
step_btn  input  1  raw asynchronous button; each accepted press issues one tick while paused.
rate_sel  input  3  run-rate select.
halt  input  1  level halt request from the CPU (for example, exit syscall).
tick  output  1  registered one-cycle CPU clock enable.
running  output  1  high in RUN state.
halted  output  1  high in HALT state.
tick_cnt  output  32  total ticks issued, wraps at 2^32.

Behaviour:
- Reset: state=IDLE; tick=0, running=0, halted=0, tick_cnt=0. Divider count and debounce counters clear, and button sync flops clear.
- Button path, applied to each button independently:
  - 2-flop synchroniser, then a stable counter.
  - A press pulse (1 cycle) fires when the synchronised level has been high for exactly DEB_CYCLES consecutive cycles.
  - After a pulse, the button must be seen low for DEB_CYCLES consecutive cycles before it is re-armed.
  - From a clean raw rise, the pulse occurs 2+DEB_CYCLES cycles later.
- Rate table, with period P = max(1, CLK_FREQ/Hz):
  - rate_sel 0..6 select 1, 4, 16, 64, 256, 1024, 4096 Hz.
  - rate_sel 7 means full speed, P=1.
  - The table is computed from CLK_FREQ at elaboration.
- Divider:
  - In RUN, cnt increments every cycle.
  - When cnt >= P-1, tick=1 on the next cycle and cnt returns to 0.
  - Using >= means a rate_sel change to a shorter period ticks immediately rather than waiting for a wrap.
  - cnt is cleared on every entry to RUN, so the first tick occurs P cycles after entry.
- State machine, evaluated on internal pulses go_p and step_p:
  - IDLE:
    - go_p -> RUN.
    - Otherwise step_p -> STEP.
    - If both fire in the same cycle, go wins and step is dropped.
  - STEP: tick=1 for exactly one cycle, then IDLE. Net effect: tick is high on the second cycle after step_p.
  - RUN:
    - halt=1 -> HALT.
    - Else go_p -> IDLE.
    - step_p is ignored.
    - Leaving RUN suppresses any tick not yet registered.
  - HALT:
    - tick stays 0.
    - go_p and step_p are ignored.
    - Exit only via rst, even if halt later deasserts.
  - halt in IDLE or STEP: go to HALT. A STEP tick already being driven in that cycle still completes.
  - halt and go_p in the same cycle: halt wins.
- Outputs:
  - running=1 iff state==RUN.
  - halted=1 iff state==HALT.
  - tick is never high in two consecutive cycles, except in RUN with P=1.
  - tick_cnt increments in the same cycle tick is high (registered alongside it) and wraps from 0xFFFFFFFF to 0.
- rst asserted mid-RUN or mid-STEP forces the reset values on the next edge. No tick is issued in that cycle.

Test Plan:
Bench setting for all scenarios: CLK_FREQ=4096, DEB_CYCLES=4.
1. Step while paused: pulse step_btn high for 10 cycles -> exactly one tick; tick_cnt=1; running=0. A 3-cycle bounce glitch produces no tick.
2. Run at rate_sel=5 (P=4): press go -> running=1. Ticks arrive every 4 cycles, first 4 cycles after entry; after 40 cycles tick_cnt=10. A second go press -> running=0 and ticks stop.
3. Full speed and rate change: RUN at rate_sel=7 -> tick every cycle. Switch to rate_sel=4 (P=16) mid-run -> next tick within 16 cycles, then every 16. Switch from rate_sel=0 (P=4096) with cnt=100 to rate_sel=5 -> tick on the next cycle.
4. Halt: RUN at rate_sel=7, assert halt for 1 cycle -> halted=1, running=0, tick=0 from the next cycle. Go and step presses are ignored. halted stays 1 after halt drops, until rst.
5. Simultaneous go+step in IDLE -> RUN entered and no single-step tick. Simultaneous halt+go in RUN -> HALT.
6. Reset: rst mid-RUN -> all outputs 0 next cycle. Force tick_cnt=0xFFFFFFFF with one tick -> tick_cnt wraps to 0.

Source files
------------

// File: rtl/cpu_clock_ctrl.sv
// Run/pause/single-step controller for the CPU clock domain.
// Produces a one-cycle clock-enable `tick` from debounced buttons, a rate table and a halt request.
module cpu_clock_ctrl #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        go_btn,
  input  logic        step_btn,
  input  logic [2:0]  rate_sel,
  input  logic        halt,
  output logic        tick,
  output logic        running,
  output logic        halted,
  output logic [31:0] tick_cnt
);

  localparam int unsigned DebW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

  function automatic int unsigned per_of(input int unsigned hz);
    return (CLK_FREQ / hz == 0) ? 1 : CLK_FREQ / hz;
  endfunction

  localparam logic [31:0] Per0 = per_of(1);
  localparam logic [31:0] Per1 = per_of(4);
  localparam logic [31:0] Per2 = per_of(16);
  localparam logic [31:0] Per3 = per_of(64);
  localparam logic [31:0] Per4 = per_of(256);
  localparam logic [31:0] Per5 = per_of(1024);
  localparam logic [31:0] Per6 = per_of(4096);

  typedef enum logic [1:0] {StIdle, StStep, StRun, StHalt} state_e;

  // Index 0 is go, index 1 is step.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      armed_q, armed_d;
  logic [1:0]      press_q, press_d;
  logic [DebW-1:0] deb_q [2];
  logic [DebW-1:0] deb_d [2];

  state_e      state_q, state_d;
  logic [31:0] div_q, div_d;
  logic [31:0] period;
  logic        tick_q, tick_d;
  logic        running_q, halted_q;
  logic [31:0] tick_cnt_q;
  logic        go_p, step_p;

  assign btn_raw = {step_btn, go_btn};
  assign go_p    = press_q[0];
  assign step_p  = press_q[1];

  // An armed button counts high cycles and fires; a disarmed one counts low cycles to re-arm.
  always_comb begin
    armed_d = armed_q;
    press_d = '0;
    for (int b = 0; b < 2; b++) begin
      deb_d[b] = '0;
      if (sync2_q[b] == armed_q[b]) begin
        if (deb_q[b] == DebLast) begin
          armed_d[b] = ~armed_q[b];
          press_d[b] = armed_q[b];
        end else begin
          deb_d[b] = deb_q[b] + DebW'(1);
        end
      end
    end
  end

  always_comb begin
    period = 32'd1;
    case (rate_sel)
      3'd0:    period = Per0;
      3'd1:    period = Per1;
      3'd2:    period = Per2;
      3'd3:    period = Per3;
      3'd4:    period = Per4;
      3'd5:    period = Per5;
      3'd6:    period = Per6;
      default: period = 32'd1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (halt) begin
          state_d = StHalt;
        end else if (go_p) begin
          state_d = StRun;
          div_d   = '0;
        end else if (step_p) begin
          state_d = StStep;
        end
      end
      StStep: begin
        tick_d  = 1'b1;
        state_d = halt ? StHalt : StIdle;
      end
      StRun: begin
        if (halt) begin
          state_d = StHalt;
        end else if (go_p) begin
          state_d = StIdle;
        end else if (div_q >= period - 32'd1) begin
          // >= lets a switch to a shorter period fire at once instead of waiting for a wrap.
          tick_d = 1'b1;
          div_d  = '0;
        end else begin
          div_d = div_q + 32'd1;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      armed_q    <= '1;
      press_q    <= '0;
      deb_q[0]   <= '0;
      deb_q[1]   <= '0;
      state_q    <= StIdle;
      div_q      <= '0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      armed_q    <= armed_d;
      press_q    <= press_d;
      deb_q      <= deb_d;
      state_q    <= state_d;
      div_q      <= div_d;
      tick_q     <= tick_d;
      running_q  <= (state_d == StRun);
      halted_q   <= (state_d == StHalt);
      tick_cnt_q <= tick_cnt_q + {31'd0, tick_d};
    end
  end

  assign tick     = tick_q;
  assign running  = running_q;
  assign halted   = halted_q;
  assign tick_cnt = tick_cnt_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with CLK_FREQ=4096, DEB_CYCLES=4.
// Inputs change and outputs are sampled on the falling edge.
module tb_cpu_clock_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go_btn = 1'b0;
  logic        step_btn = 1'b0;
  logic [2:0]  rate_sel = 3'd5;
  logic        halt = 1'b0;
  logic        tick, running, halted;
  logic [31:0] tick_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cpu_clock_ctrl #(
    .CLK_FREQ  (4096),
    .DEB_CYCLES(4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .go_btn  (go_btn),
    .step_btn(step_btn),
    .rate_sel(rate_sel),
    .halt    (halt),
    .tick    (tick),
    .running (running),
    .halted  (halted),
    .tick_cnt(tick_cnt)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got %b want 0", tick); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running got %b want 0", running); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
    n_cmp++; if (tick_cnt !== 32'd0) begin n_bad++; $display("FAIL reset_cnt got %0d want 0", tick_cnt); end
    rst = 1'b0;
  endtask

  // Press lands 6 cycles after the raw rise, STEP follows, tick two cycles after the pulse.
  task automatic test_step();
    logic exp_t;
    step_btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_t = (i == 8);
      n_cmp++; if (tick !== exp_t) begin n_bad++; $display("FAIL step_tick i=%0d got %b want %b", i, tick, exp_t); end
      if (i == 10) step_btn = 1'b0;
    end
    n_cmp++; if (tick_cnt !== 32'd1) begin n_bad++; $display("FAIL step_cnt got %0d want 1", tick_cnt); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL step_running got %b want 0", running); end
    repeat (8) @(negedge clk);
    step_btn = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL glitch_tick i=%0d got %b want 0", i, tick); end
      if (i == 3) step_btn = 1'b0;
    end
    n_cmp++; if (tick_cnt !== 32'd1) begin n_bad++; $display("FAIL glitch_cnt got %0d want 1", tick_cnt); end
  endtask

  // P=4: enter RUN at 7, ticks 11..51; second go pulse at 54 suppresses the tick due at 55.
  task automatic test_run();
    logic exp_t, exp_r;
    rate_sel = 3'd5;
    go_btn = 1'b1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      exp_t = (i >= 11) && (i <= 51) && ((i - 11) % 4 == 0);
      exp_r = (i >= 7) && (i <= 54);
      n_cmp++; if (tick !== exp_t) begin n_bad++; $display("FAIL run_tick i=%0d got %b want %b", i, tick, exp_t); end
      n_cmp++; if (running !== exp_r) begin n_bad++; $display("FAIL run_running i=%0d got %b want %b", i, running, exp_r); end
      if (i == 47) begin
        n_cmp++; if (tick_cnt !== 32'd11) begin n_bad++; $display("FAIL run_cnt40 got %0d want 11", tick_cnt); end
      end
      if (i == 8) go_btn = 1'b0;
      if (i == 48) go_btn = 1'b1;
      if (i == 56) go_btn = 1'b0;
    end
    n_cmp++; if (tick_cnt !== 32'd12) begin n_bad++; $display("FAIL run_cnt_end got %0d want 12", tick_cnt); end
  endtask

  // Full speed, then P=16, then P=4096 until cnt=100, then P=4; leaves RUN at full speed.
  task automatic test_rates();
    logic exp_t;
    rate_sel = 3'd7;
    go_btn = 1'b1;
    for (int j = 1; j <= 165; j++) begin
      @(negedge clk);
      exp_t = ((j >= 8) && (j <= 12)) || (j == 28) || (j == 44) || (j == 60) ||
              (j == 161) || (j == 165);
      n_cmp++; if (tick !== exp_t) begin n_bad++; $display("FAIL rate_tick j=%0d got %b want %b", j, tick, exp_t); end
      if (j == 7) begin
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL rate_running got %b want 1", running); end
      end
      if (j == 8) go_btn = 1'b0;
      if (j == 12) rate_sel = 3'd4;
      if (j == 60) rate_sel = 3'd0;
      if (j == 160) rate_sel = 3'd5;
      if (j == 165) rate_sel = 3'd7;
    end
    n_cmp++; if (tick_cnt !== 32'd22) begin n_bad++; $display("FAIL rate_cnt got %0d want 22", tick_cnt); end
  endtask

  task automatic test_halt();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL full_tick k=%0d got %b want 1", k, tick); end
    end
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_halted got %b want 1", halted); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL halt_running got %b want 0", running); end
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL halt_tick got %b want 0", tick); end
    n_cmp++; if (tick_cnt !== 32'd27) begin n_bad++; $display("FAIL halt_cnt got %0d want 27", tick_cnt); end
    go_btn = 1'b1;
    step_btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL halt_hold_tick k=%0d got %b want 0", k, tick); end
      n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL halt_hold k=%0d got %b want 1", k, halted); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL halt_hold_run k=%0d got %b want 0", k, running); end
      if (k == 8) begin
        go_btn = 1'b0;
        step_btn = 1'b0;
      end
    end
    n_cmp++; if (tick_cnt !== 32'd27) begin n_bad++; $display("FAIL halt_cnt_end got %0d want 27", tick_cnt); end
  endtask

  // go+step together: RUN, no step tick at 8. Later go+halt together in RUN: HALT.
  task automatic test_simul();
    logic exp_t, exp_r;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rate_sel = 3'd5;
    go_btn = 1'b1;
    step_btn = 1'b1;
    for (int j = 1; j <= 28; j++) begin
      @(negedge clk);
      exp_t = (j == 11) || (j == 15) || (j == 19) || (j == 23);
      exp_r = (j >= 7) && (j <= 26);
      n_cmp++; if (tick !== exp_t) begin n_bad++; $display("FAIL simul_tick j=%0d got %b want %b", j, tick, exp_t); end
      n_cmp++; if (running !== exp_r) begin n_bad++; $display("FAIL simul_running j=%0d got %b want %b", j, running, exp_r); end
      if (j == 8) begin
        go_btn = 1'b0;
        step_btn = 1'b0;
      end
      if (j == 20) go_btn = 1'b1;
      if (j == 26) halt = 1'b1;
      if (j == 27) begin
        n_cmp++; if (halted !== 1'b1) begin n_bad++; $display("FAIL simul_halted got %b want 1", halted); end
        n_cmp++; if (tick_cnt !== 32'd4) begin n_bad++; $display("FAIL simul_cnt got %0d want 4", tick_cnt); end
        halt = 1'b0;
      end
      if (j == 28) go_btn = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rate_sel = 3'd7;
    go_btn = 1'b1;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      if (j >= 8 && j <= 10) begin
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL mid_tick j=%0d got %b want 1", j, tick); end
      end
      if (j == 8) go_btn = 1'b0;
      if (j == 10) rst = 1'b1;
    end
    rst = 1'b0;
    n_cmp++; if (tick !== 1'b0) begin n_bad++; $display("FAIL mid_rst_tick got %b want 0", tick); end
    n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL mid_rst_running got %b want 0", running); end
    n_cmp++; if (halted !== 1'b0) begin n_bad++; $display("FAIL mid_rst_halted got %b want 0", halted); end
    n_cmp++; if (tick_cnt !== 32'd0) begin n_bad++; $display("FAIL mid_rst_cnt got %0d want 0", tick_cnt); end
  endtask

  task automatic test_wrap();
    dut.tick_cnt_q <= 32'hFFFF_FFFF;
    step_btn = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk);
      if (j == 7) begin
        n_cmp++; if (tick_cnt !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL wrap_pre got %h want ffffffff", tick_cnt); end
      end
      if (j == 8) begin
        n_cmp++; if (tick !== 1'b1) begin n_bad++; $display("FAIL wrap_tick got %b want 1", tick); end
        n_cmp++; if (tick_cnt !== 32'd0) begin n_bad++; $display("FAIL wrap_cnt got %h want 00000000", tick_cnt); end
      end
      if (j == 10) step_btn = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_step();
    test_run();
    test_rates();
    test_halt();
    test_simul();
    test_reset_mid_run();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
